register_file_multiport: RTL

//  Parametrised CPU general-purpose register file: N read ports, M write ports, optional hardwired zero register.

---
 rtl/register_file_multiport.sv | 139 +++++++++++++
 1 files changed

// File: rtl/register_file_multiport.sv
// Multiport CPU register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard for stalling on pending results.
module register_file_multiport #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 16,
  parameter int NUM_READ_PORTS  = 3,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int SYNC_READ       = 1,
  parameter int ZERO_REG        = 1,
  localparam int SEL_W          = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_READ_PORTS*SEL_W-1:0]      rd_sel,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  input  logic [NUM_WRITE_PORTS-1:0]           wr_en,
  input  logic [NUM_WRITE_PORTS*SEL_W-1:0]     wr_sel,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                                 claim_en,
  input  logic [SEL_W-1:0]                     claim_sel,
  output logic [NUM_REGS-1:0]                  busy_vec,
  output logic                                 wr_conflict
);

  logic [DATA_WIDTH-1:0]                 regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]                   busy_reg;
  logic [NUM_REGS-1:0]                   busy_next;
  logic [NUM_WRITE_PORTS-1:0]            wr_eff;
  logic [NUM_REGS-1:0]                   wr_hit;
  logic [DATA_WIDTH-1:0]                 wr_val [NUM_REGS];
  logic                                  conflict_next;
  logic                                  wr_conflict_reg;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_val_all;
  logic [NUM_READ_PORTS-1:0]             rd_busy_sel;

  genvar gi;

  // Writes to the zero register are never effective, so they can't collide or bypass.
  generate
    for (gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_wr_eff
      assign wr_eff[gi] = wr_en[gi] &&
                          !(ZERO_REG != 0 && wr_sel[gi*SEL_W +: SEL_W] == '0);
    end
  endgenerate

  // Per-register winning write: ascending scan so the highest port index wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (wr_eff[p] && wr_sel[p*SEL_W +: SEL_W] == SEL_W'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int p = 1; p < NUM_WRITE_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_eff[p] && wr_eff[q] &&
            wr_sel[p*SEL_W +: SEL_W] == wr_sel[q*SEL_W +: SEL_W]) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  // A claim marks a new producer pending, so it overrides a same-cycle writeback.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy_next
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_norm
        assign busy_next[gi] = (claim_en && claim_sel == SEL_W'(gi)) ? 1'b1 :
                               wr_hit[gi]                            ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg        <= '0;
      wr_conflict_reg <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_reg[r] <= wr_val[r];
        end
      end
      busy_reg        <= busy_next;
      wr_conflict_reg <= conflict_next;
    end
  end

  assign busy_vec    = busy_reg;
  assign wr_conflict = wr_conflict_reg;

  // Registered reads see next-cycle state (bypassed data, next busy) so they line up.
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd_port
      logic [SEL_W-1:0] sel;
      assign sel = rd_sel[gi*SEL_W +: SEL_W];
      assign rd_val_all[gi*DATA_WIDTH +: DATA_WIDTH] =
          (ZERO_REG != 0 && sel == '0) ? '0          :
          wr_hit[sel]                  ? wr_val[sel] :
          regs_reg[sel];
      assign rd_busy_sel[gi] = (SYNC_READ != 0) ? busy_next[sel] : busy_reg[sel];
    end

    if (SYNC_READ != 0) begin : g_sync_rd
      logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_reg;
      logic [NUM_READ_PORTS-1:0]            rd_busy_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg <= '0;
          rd_busy_reg <= '0;
        end else begin
          rd_data_reg <= rd_val_all;
          rd_busy_reg <= rd_busy_sel;
        end
      end
      assign rd_data = rd_data_reg;
      assign rd_busy = rd_busy_reg;
    end else begin : g_comb_rd
      assign rd_data = rd_val_all;
      assign rd_busy = rd_busy_sel;
    end
  endgenerate

endmodule
